// File: rtl/ft600_pkg.sv
// ----------------------------------------------------------------------------
// ft600_pkg
// Constants and FSM state encoding shared by the FT600 245-synchronous-FIFO
// receive and transmit engines.
//   DATA_WIDTH : FT600 data bus width
//   BE_WIDTH   : byte-enable width (one bit per data byte)
//   ft_state_e : bus-owning FSM states (idle, turnaround, transfer, release)
// ----------------------------------------------------------------------------
package ft600_pkg;

   localparam int DATA_WIDTH = 16;
   localparam int BE_WIDTH   = DATA_WIDTH / 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OE   = 2'd1,
      ST_READ = 2'd2,
      ST_DONE = 2'd3
   } ft_state_e;

endpackage

// File: rtl/sync_fwft_fifo.sv
// ----------------------------------------------------------------------------
// sync_fwft_fifo
// Single-clock first-word-fall-through FIFO: circular RAM, wrapping pointers and
// a separate occupancy counter. The head entry is always visible on dout.
//   clk, rst : clock, asynchronous active-low reset (pointers and count only)
//   push/din : write din at the write pointer
//   pop      : advance the read pointer (ignored while empty)
//   dout     : entry at the read pointer
//   count    : occupancy 0..2**ADDR_WIDTH
//   empty    : count == 0
//   full     : count == 2**ADDR_WIDTH
// ----------------------------------------------------------------------------
module sync_fwft_fifo #(
   parameter int WIDTH      = 18,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                push,
   input  logic                pop,
   input  logic [WIDTH-1:0]    din,
   output logic [WIDTH-1:0]    dout,
   output logic [ADDR_WIDTH:0] count,
   output logic                empty,
   output logic                full
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] PTR_ZERO = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [WIDTH-1:0]      mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_q;
   logic [ADDR_WIDTH-1:0] wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_d;
   logic [ADDR_WIDTH:0]   count_q;
   logic [ADDR_WIDTH:0]   count_d;
   logic                  empty_s;
   logic                  full_s;
   logic                  pop_ok_s;
   logic                  push_ok_s;

   assign empty_s   = (count_q == CNT_ZERO);
   assign full_s    = (count_q == CNT_FULL);
   assign pop_ok_s  = pop && !empty_s;
   // At full a write is accepted only alongside a read, which frees the slot.
   assign push_ok_s = push && (!full_s || pop_ok_s);

   // Next-state pointers and occupancy; pointers wrap naturally at DEPTH
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; contents are abandoned on reset
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q <= PTR_ZERO;
         rd_ptr_q <= PTR_ZERO;
         count_q  <= CNT_ZERO;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; no reset so it maps onto plain RAM
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = empty_s;
   assign full  = full_s;

   sync_fwft_fifo_chk #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_chk (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop_ok_s),
      .full  (full_s),
      .empty (empty_s),
      .count (count_q)
   );

endmodule

// File: rtl/sync_fwft_fifo_chk.sv
// ----------------------------------------------------------------------------
// sync_fwft_fifo_chk
// Property checker for sync_fwft_fifo; observes only, drives nothing.
//   clk, rst : clock and asynchronous active-low reset of the observed FIFO
//   push     : write request as presented to the FIFO
//   pop      : accepted read (already qualified by non-empty)
//   full     : FIFO full flag
//   empty    : FIFO empty flag
//   count    : FIFO occupancy
// ----------------------------------------------------------------------------
module sync_fwft_fifo_chk #(
   parameter int ADDR_WIDTH = 4
) (
   input logic                clk,
   input logic                rst,
   input logic                push,
   input logic                pop,
   input logic                full,
   input logic                empty,
   input logic [ADDR_WIDTH:0] count
);

   localparam logic [ADDR_WIDTH:0] CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0] CNT_FULL = {1'b1, {ADDR_WIDTH{1'b0}}};

   // A write into a full buffer is only legal when a read frees a slot on the same edge
   a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(push && full && !pop));

   // Occupancy never exceeds the buffer depth
   a_count_range: assert property (@(posedge clk) disable iff (!rst)
      count <= CNT_FULL);

   // Empty flag agrees with the occupancy counter
   a_empty_flag: assert property (@(posedge clk) disable iff (!rst)
      empty == (count == CNT_ZERO));

endmodule

// File: rtl/ft600_mode245_rx_engine.sv
// ----------------------------------------------------------------------------
// ft600_mode245_rx_engine
// Receive engine for the FT600 245-synchronous-FIFO bus. When the FT600 has
// data, the arbiter grants the bus and there is room, it runs one burst
// (OE turnaround, READ, DONE) and drains words into a local FWFT buffer.
//   clk       : ft_clk, all logic on the rising edge
//   rst       : asynchronous reset, active-low
//   ft_data   : FT600 data bus (sampled only)
//   ft_be     : FT600 byte enables (sampled with data)
//   ft_rxf    : active-low, FT600 holds data to read
//   ft_oe     : active-low FT600 output enable (registered)
//   ft_rd     : active-low read strobe (registered)
//   bus_gnt   : arbiter grant, only consulted when starting a burst
//   busy      : bus owned, high from OE through DONE (registered)
//   rx_en     : pop request from user logic
//   rx_out    : head-of-buffer data
//   rx_be     : head-of-buffer byte enables
//   rx_empty  : buffer empty
//   rx_count  : buffer occupancy 0..2**RX_BUF_WIDTH
// ----------------------------------------------------------------------------
module ft600_mode245_rx_engine #(
   parameter int RX_BUF_WIDTH = 4,
   parameter int DATA_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_WIDTH-1:0]   ft_data,
   input  logic [DATA_WIDTH/8-1:0] ft_be,
   input  logic                    ft_rxf,
   output logic                    ft_oe,
   output logic                    ft_rd,
   input  logic                    bus_gnt,
   output logic                    busy,
   input  logic                    rx_en,
   output logic [DATA_WIDTH-1:0]   rx_out,
   output logic [DATA_WIDTH/8-1:0] rx_be,
   output logic                    rx_empty,
   output logic [RX_BUF_WIDTH:0]   rx_count
);

   import ft600_pkg::*;

   localparam int BE_W   = DATA_WIDTH / 8;
   localparam int WORD_W = DATA_WIDTH + BE_W;
   // Occupancy one below full: a lone push from here fills the buffer.
   localparam logic [RX_BUF_WIDTH:0] CNT_LAST = {1'b0, {RX_BUF_WIDTH{1'b1}}};

   ft_state_e             state_q;
   ft_state_e             state_d;
   logic                  ft_oe_q;
   logic                  ft_oe_d;
   logic                  ft_rd_q;
   logic                  ft_rd_d;
   logic                  busy_q;
   logic                  busy_d;

   logic                  push_s;
   logic                  pop_s;
   logic [WORD_W-1:0]     fifo_dout_s;
   logic [RX_BUF_WIDTH:0] fifo_count_s;
   logic                  fifo_empty_s;
   logic                  fifo_full_s;

   // A word moves on every edge where our strobe is low and the FT600 still has data.
   assign push_s = (state_q == ST_READ) && !ft_rd_q && !ft_rxf;
   assign pop_s  = rx_en && !fifo_empty_s;

   // Next state and next registered bus controls
   always_comb begin
      state_d = state_q;
      ft_oe_d = 1'b1;
      ft_rd_d = 1'b1;
      busy_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!ft_rxf && bus_gnt && !fifo_full_s) begin
               state_d = ST_OE;
               ft_oe_d = 1'b0;
               busy_d  = 1'b1;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_OE: begin
            busy_d = 1'b1;
            if (!ft_rxf) begin
               state_d = ST_READ;
               ft_oe_d = 1'b0;
               ft_rd_d = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         ST_READ: begin
            busy_d = 1'b1;
            // Stop on the very edge that fills the buffer so ft_rd rises
            // before a word could be sampled with nowhere to put it.
            if (ft_rxf || (push_s && !pop_s && (fifo_count_s == CNT_LAST))) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_READ;
               ft_oe_d = 1'b0;
               ft_rd_d = 1'b0;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // FSM state and bus-control registers; reset releases the bus immediately
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         ft_oe_q <= 1'b1;
         ft_rd_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ft_oe_q <= ft_oe_d;
         ft_rd_q <= ft_rd_d;
         busy_q  <= busy_d;
      end
   end

   sync_fwft_fifo #(
      .WIDTH      (WORD_W),
      .ADDR_WIDTH (RX_BUF_WIDTH)
   ) u_rx_buf (
      .clk   (clk),
      .rst   (rst),
      .push  (push_s),
      .pop   (pop_s),
      .din   ({ft_be, ft_data}),
      .dout  (fifo_dout_s),
      .count (fifo_count_s),
      .empty (fifo_empty_s),
      .full  (fifo_full_s)
   );

   assign ft_oe    = ft_oe_q;
   assign ft_rd    = ft_rd_q;
   assign busy     = busy_q;
   assign rx_out   = fifo_dout_s[DATA_WIDTH-1:0];
   assign rx_be    = fifo_dout_s[WORD_W-1:DATA_WIDTH];
   assign rx_empty = fifo_empty_s;
   assign rx_count = fifo_count_s;

endmodule

// File: doc/ft600_mode245_rx_engine.md
Name: ft600_mode245_rx_engine

Overview:
- Receive-direction engine for the FT600 245-synchronous-FIFO interface: drains host-to-FPGA words from the FT600 into a local FWFT buffer read by user logic.
- Lives entirely in the ft_clk domain; sits beside the TX path, with a grant input so a top-level arbiter can share the half-duplex bus.
- The top level owns the ft_data/ft_be tristates; this block only samples them.

Parameters:
- RX_BUF_WIDTH, 4, log2 of buffer depth (DEPTH = 16 words).
- DATA_WIDTH, 16, FT600 data bus width; byte-enable width = DATA_WIDTH/8.

Ports:
- clk  in  1  FT600 clock (ft_clk), all logic on rising edge
- rst  in  1  asynchronous reset, active-low
- ft_data  in  16  FT600 data bus, sampled only
- ft_be  in  2  FT600 byte enables, sampled with data
- ft_rxf  in  1  active-low: FT600 holds data to read
- ft_oe  out  1  active-low: FT600 output enable
- ft_rd  out  1  active-low: read strobe
- bus_gnt  in  1  arbiter grant; a burst may start only while high
- busy  out  1  high from OE through DONE (bus owned)
- rx_en  in  1  pop request from user logic
- rx_out  out  16  head-of-buffer data (FWFT)
- rx_be  out  2  head-of-buffer byte enables
- rx_empty  out  1  buffer empty
- rx_count  out  RX_BUF_WIDTH+1  current occupancy, 0..DEPTH

Behaviour:
- Reset (rst low, async): state IDLE, ft_oe=1, ft_rd=1, busy=0, rx_empty=1, rx_count=0, pointers 0. rx_out/rx_be are don't-care while empty.
- All of ft_oe, ft_rd and busy are registered outputs.
- FSM states: IDLE, OE, READ, DONE.
  - IDLE -> OE when ft_rxf==0 && bus_gnt==1 && rx_count<DEPTH. In OE: ft_oe=0, ft_rd=1, busy=1 (one bus-turnaround cycle).
  - OE -> READ if ft_rxf==0; else OE -> DONE. In READ: ft_oe=0, ft_rd=0.
  - READ: on each edge where ft_rd==0 && ft_rxf==0, push {ft_be, ft_data} into the buffer.
  - READ -> DONE when ft_rxf==1, or when this edge's push (with no concurrent pop) brings occupancy to DEPTH. ft_rd rises on the same edge, so no word is sampled past full.
  - DONE: ft_oe=1, ft_rd=1, busy=1 for exactly one cycle; DONE -> IDLE.
- bus_gnt is checked only in IDLE. Deasserting it mid-burst does not abort; the arbiter waits for busy=0.
- Buffer: DEPTH-entry circular RAM of 18-bit words; pointers wrap modulo DEPTH; rx_count is a separate counter.
  - rx_out/rx_be always show the entry at the read pointer.
  - Pop when rx_en && !rx_empty; rx_en on empty is ignored.
  - Push and pop on the same edge: both pointers advance, count unchanged. This is legal at full, and pop-then-refill does not terminate the burst.
  - Push is impossible when full; the FSM guarantees this, and an assertion checks it.
- Latency: word sampled at edge k is visible on rx_out, with rx_empty=0, after edge k.
- Minimum burst overhead: 1 OE cycle + 1 DONE cycle.
- Reset mid-burst: immediate return to reset values; ft_oe/ft_rd release asynchronously; buffer contents discarded.

Decomposition:
- Shared package ft600_pkg: DATA_WIDTH, BE_WIDTH, FSM state encoding (IDLE/OE/READ/DONE); the TX engine reuses the same constants.
- One sub-module, sync_fwft_fifo (WIDTH, ADDR_WIDTH: push, pop, dout, count, empty, full). The engine instantiates it with WIDTH=18.

Test Plan:
1. Reset: hold rst=0 for 100 ns with ft_rxf=0 -> ft_oe=1, ft_rd=1, rx_empty=1, rx_count=0, busy=0 throughout.
2. Short burst: bus_gnt=1, host model presents 0x0001..0x0005 with be=2'b11, then ft_rxf=1 -> ft_oe falls 1 cycle before ft_rd; rx_count=5; pops return 0x0001..0x0005 in order; DONE lasts one cycle; busy=0 afterwards.
3. Full stop: rx_en=0, host offers 40 words -> exactly 16 words accepted, ft_rd rises on the edge the 16th is sampled; popping 1 word starts a new burst, which accepts word 17 (0x0011) and stops full again.
4. Concurrent pop: rx_en=1 continuously during a 40-word burst -> all 40 words received in order, rx_count stays at most 1, no early DONE.
5. Grant gating: ft_rxf=0, bus_gnt=0 for 20 cycles -> ft_oe/ft_rd stay 1. Raise bus_gnt -> OE on the next edge. Drop bus_gnt mid-burst -> burst completes normally.
6. Reset mid-READ after 3 words -> ft_oe/ft_rd=1 immediately, rx_empty=1. After release, a fresh burst delivers 0x00A0 as the first word, with be=2'b01 preserved on rx_be.
